// File: rtl/regbank_pkg.sv
// Shared defaults, load-FSM state type and address-width helper for param_register_bank.
package regbank_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_NUM_GP = 28;
  localparam int unsigned DEF_NUM_PI = 2;
  localparam int unsigned DEF_NUM_PO = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  // Selector width able to encode every address up to and including w_addr.
  function automatic int unsigned sel_width(input int unsigned w_addr);
    return $clog2(w_addr + 1);
  endfunction

endpackage

// File: rtl/regbank_read_mux.sv
// One read-port address decode: GP registers, input ports, output ports, W, else zero.
module regbank_read_mux
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NUM_GP = DEF_NUM_GP,
  parameter int unsigned NUM_PI = DEF_NUM_PI,
  parameter int unsigned NUM_PO = DEF_NUM_PO,
  parameter int unsigned SEL_W  = sel_width(NUM_GP + NUM_PI + NUM_PO)
) (
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_GP*DATA_W-1:0] gp_i,
  input  logic [NUM_PI*DATA_W-1:0] pi_i,
  input  logic [NUM_PO*DATA_W-1:0] po_i,
  input  logic [DATA_W-1:0]        w_i,
  output logic [DATA_W-1:0]        rd_o
);

  localparam int unsigned PI_BASE = NUM_GP;
  localparam int unsigned PO_BASE = NUM_GP + NUM_PI;
  localparam int unsigned W_ADDR  = NUM_GP + NUM_PI + NUM_PO;

  always_comb begin
    rd_o = '0;
    for (int unsigned i = 0; i < NUM_GP; i++)
      if (sel_i == SEL_W'(i)) rd_o = gp_i[i*DATA_W +: DATA_W];
    for (int unsigned k = 0; k < NUM_PI; k++)
      if (sel_i == SEL_W'(PI_BASE + k)) rd_o = pi_i[k*DATA_W +: DATA_W];
    for (int unsigned k = 0; k < NUM_PO; k++)
      if (sel_i == SEL_W'(PO_BASE + k)) rd_o = po_i[k*DATA_W +: DATA_W];
    if (sel_i == SEL_W'(W_ADDR)) rd_o = w_i;
  end

endmodule

// File: rtl/param_register_bank.sv
// Register bank with GP/PI/PO/W address map, two read ports and a memory load/store FSM for W.
// Optional same-cycle write forwarding to the read ports when REGBANK_BYPASS_EN is defined.
module param_register_bank
  import regbank_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned NUM_GP = DEF_NUM_GP,
  parameter  int unsigned NUM_PI = DEF_NUM_PI,
  parameter  int unsigned NUM_PO = DEF_NUM_PO,
  localparam int unsigned W_ADDR = NUM_GP + NUM_PI + NUM_PO,
  localparam int unsigned SEL_W  = sel_width(W_ADDR)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel_a,
  input  logic [SEL_W-1:0]         sel_b,
  output logic [DATA_W-1:0]        data_a,
  output logic [DATA_W-1:0]        data_b,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         sel_c,
  input  logic [DATA_W-1:0]        data_c,
  input  logic                     mem_rd_req,
  input  logic                     mem_wr_req,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  output logic                     busy,
  input  logic [NUM_PI*DATA_W-1:0] pi,
  output logic [NUM_PO*DATA_W-1:0] po,
  output logic [DATA_W-1:0]        w_out
);

  localparam int unsigned PO_BASE = NUM_GP + NUM_PI;
  localparam logic [SEL_W-1:0] W_SEL = SEL_W'(W_ADDR);

  logic [NUM_GP-1:0][DATA_W-1:0] gp_q, gp_d;
  logic [NUM_PO-1:0][DATA_W-1:0] po_q, po_d;
  logic [DATA_W-1:0]             w_q, w_d;
  state_e                        state_q, state_d;
  logic                          w_wr;
  logic [DATA_W-1:0]             rd_a, rd_b;

  // A direct write to W is only honoured while no load owns W.
  assign w_wr = wr_en && (sel_c == W_SEL) && (state_q == ST_IDLE);

  always_comb begin
    gp_d    = gp_q;
    po_d    = po_q;
    w_d     = w_q;
    state_d = state_q;
    for (int unsigned i = 0; i < NUM_GP; i++)
      if (wr_en && sel_c == SEL_W'(i)) gp_d[i] = data_c;
    for (int unsigned k = 0; k < NUM_PO; k++)
      if (wr_en && sel_c == SEL_W'(PO_BASE + k)) po_d[k] = data_c;
    case (state_q)
      ST_IDLE: begin
        if (w_wr) w_d = data_c;
        if (mem_rd_req) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          w_d     = mem_rdata;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gp_q    <= '0;
      po_q    <= '0;
      w_q     <= '0;
      state_q <= ST_IDLE;
    end else begin
      gp_q    <= gp_d;
      po_q    <= po_d;
      w_q     <= w_d;
      state_q <= state_d;
    end
  end

  assign mem_we    = !reset && (state_q == ST_IDLE) && mem_wr_req;
  assign mem_wdata = w_q;
  assign busy      = (state_q == ST_RD_WAIT);
  assign po        = po_q;
  assign w_out     = w_q;

  regbank_read_mux #(
    .DATA_W(DATA_W), .NUM_GP(NUM_GP), .NUM_PI(NUM_PI), .NUM_PO(NUM_PO), .SEL_W(SEL_W)
  ) u_mux_a (
    .sel_i(sel_a), .gp_i(gp_q), .pi_i(pi), .po_i(po_q), .w_i(w_q), .rd_o(rd_a)
  );

  regbank_read_mux #(
    .DATA_W(DATA_W), .NUM_GP(NUM_GP), .NUM_PI(NUM_PI), .NUM_PO(NUM_PO), .SEL_W(SEL_W)
  ) u_mux_b (
    .sel_i(sel_b), .gp_i(gp_q), .pi_i(pi), .po_i(po_q), .w_i(w_q), .rd_o(rd_b)
  );

`ifdef REGBANK_BYPASS_EN
  logic c_hit;

  always_comb begin
    c_hit = w_wr || (wr_en && (sel_c < SEL_W'(NUM_GP)));
    if (wr_en && sel_c >= SEL_W'(PO_BASE) && sel_c < W_SEL) c_hit = 1'b1;
  end

  assign data_a = (c_hit && sel_c == sel_a) ? data_c : rd_a;
  assign data_b = (c_hit && sel_c == sel_b) ? data_c : rd_b;
`else
  assign data_a = rd_a;
  assign data_b = rd_b;
`endif

endmodule

// File: tb/tb_param_register_bank.sv
// Scoreboard bench for param_register_bank: directed scenarios then random traffic vs. an array model.
module tb_param_register_bank;

  localparam int DATA_W = 16;
  localparam int NUM_GP = 28;
  localparam int NUM_PI = 2;
  localparam int NUM_PO = 2;
  localparam int W_ADDR = NUM_GP + NUM_PI + NUM_PO;
  localparam int SEL_W  = 6;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [SEL_W-1:0]         sel_a, sel_b, sel_c;
  logic [DATA_W-1:0]        data_a, data_b, data_c;
  logic                     wr_en;
  logic                     mem_rd_req, mem_wr_req, mem_rvalid;
  logic [DATA_W-1:0]        mem_rdata, mem_wdata;
  logic                     mem_we, busy;
  logic [NUM_PI*DATA_W-1:0] pi;
  logic [NUM_PO*DATA_W-1:0] po;
  logic [DATA_W-1:0]        w_out;

  always #5 clk = ~clk;

  param_register_bank dut (
    .clk(clk), .reset(reset),
    .sel_a(sel_a), .sel_b(sel_b), .data_a(data_a), .data_b(data_b),
    .wr_en(wr_en), .sel_c(sel_c), .data_c(data_c),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy),
    .pi(pi), .po(po), .w_out(w_out)
  );

  typedef struct {
    logic [DATA_W-1:0]        a, b, wdata, w;
    logic                     we, bsy;
    logic [NUM_PO*DATA_W-1:0] po;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: plain arrays plus a "load pending" flag.
  logic [DATA_W-1:0] m_gp[NUM_GP];
  logic [DATA_W-1:0] m_po[NUM_PO];
  logic [DATA_W-1:0] m_w;
  bit                m_pending;

  function automatic logic [DATA_W-1:0] m_read(input int addr);
    if (addr < NUM_GP) return m_gp[addr];
    if (addr < NUM_GP + NUM_PI) return pi[(addr - NUM_GP)*DATA_W +: DATA_W];
    if (addr < W_ADDR) return m_po[addr - NUM_GP - NUM_PI];
    if (addr == W_ADDR) return m_w;
    return '0;
  endfunction

  function automatic bit m_accepts_write(input int addr);
    if (addr < NUM_GP) return 1'b1;
    if (addr >= NUM_GP + NUM_PI && addr < W_ADDR) return 1'b1;
    if (addr == W_ADDR) return !m_pending;
    return 1'b0;
  endfunction

  function automatic logic [NUM_PO*DATA_W-1:0] m_po_flat();
    logic [NUM_PO*DATA_W-1:0] f;
    for (int k = 0; k < NUM_PO; k++) f[k*DATA_W +: DATA_W] = m_po[k];
    return f;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NUM_GP; i++) m_gp[i] = '0;
    for (int k = 0; k < NUM_PO; k++) m_po[k] = '0;
    m_w       = '0;
    m_pending = 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Push the expected combinational view for the current inputs, then advance one edge.
  task automatic step();
    exp_t e;
    e.a = m_read(int'(sel_a));
    e.b = m_read(int'(sel_b));
`ifdef REGBANK_BYPASS_EN
    if (wr_en && m_accepts_write(int'(sel_c)) && sel_c == sel_a) e.a = data_c;
    if (wr_en && m_accepts_write(int'(sel_c)) && sel_c == sel_b) e.b = data_c;
`endif
    e.we    = !reset && !m_pending && mem_wr_req;
    e.wdata = m_w;
    e.w     = m_w;
    e.bsy   = m_pending;
    e.po    = m_po_flat();
    q.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_clear();
    end else begin
      if (wr_en && m_accepts_write(int'(sel_c))) begin
        if (int'(sel_c) < NUM_GP) m_gp[int'(sel_c)] = data_c;
        else if (int'(sel_c) < W_ADDR) m_po[int'(sel_c) - NUM_GP - NUM_PI] = data_c;
        else m_w = data_c;
      end
      if (m_pending) begin
        if (mem_rvalid) begin
          m_w       = mem_rdata;
          m_pending = 1'b0;
        end
      end else if (mem_rd_req) begin
        m_pending = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; wr_en = 0; sel_c = '0; data_c = '0;
    mem_rd_req = 0; mem_wr_req = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("data_a", 64'(data_a), 64'(e.a));
      chk("data_b", 64'(data_b), 64'(e.b));
      chk("mem_we", 64'(mem_we), 64'(e.we));
      chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
      chk("busy", 64'(busy), 64'(e.bsy));
      chk("w_out", 64'(w_out), 64'(e.w));
      chk("po", 64'(po), 64'(e.po));
    end
  end

  initial begin
    idle_inputs();
    reset = 1; sel_a = '0; sel_b = '0; pi = '0;
    @(posedge clk); @(posedge clk); #1;
    m_clear();
    reset = 0;

    // Reset state and GP write visible only from the next cycle.
    sel_a = 6'd5; sel_b = 6'(W_ADDR); step();
    wr_en = 1; sel_c = 6'd5; data_c = 16'hBEEF; step();
    idle_inputs(); step();

    // Writes to an input port are dropped.
    pi = {16'h9876, 16'h1234}; sel_b = 6'(NUM_GP);
    wr_en = 1; sel_c = 6'(NUM_GP); data_c = 16'hFFFF; step();
    idle_inputs(); step();
    sel_a = 6'(NUM_GP + 1); step();

    // Store and load issued together; load completes three cycles later.
    wr_en = 1; sel_c = 6'(W_ADDR); data_c = 16'h00AA; sel_a = 6'(W_ADDR); step();
    idle_inputs(); mem_rd_req = 1; mem_wr_req = 1; step();
    idle_inputs(); mem_wr_req = 1; step();
    idle_inputs(); step();
    mem_rvalid = 1; mem_rdata = 16'h5555; step();
    idle_inputs(); step();

    // Load beats a same-cycle write to W; PO writes proceed during the wait.
    mem_rd_req = 1; step();
    idle_inputs(); wr_en = 1; sel_c = 6'(W_ADDR); data_c = 16'h3C3C; step();
    sel_c = 6'(NUM_GP + NUM_PI); data_c = 16'hA5A5; mem_rvalid = 0; step();
    wr_en = 1; sel_c = 6'(W_ADDR); data_c = 16'h0F0F;
    mem_rvalid = 1; mem_rdata = 16'h1111; step();
    idle_inputs(); mem_rvalid = 1; mem_rdata = 16'h2222; step();
    idle_inputs(); step();

    // Write with store in IDLE: store carries old W.
    wr_en = 1; sel_c = 6'(W_ADDR); data_c = 16'h4444; mem_wr_req = 1; step();
    idle_inputs(); step();

    // Same-cycle read of a register being written.
    sel_a = 6'd3; wr_en = 1; sel_c = 6'd3; data_c = 16'hCAFE; step();
    idle_inputs(); step();

    // Reset abandons a pending load.
    mem_rd_req = 1; step();
    idle_inputs(); step();
    reset = 1; mem_wr_req = 1; step();
    idle_inputs(); mem_rvalid = 1; mem_rdata = 16'h7777; step();
    idle_inputs(); step();

    // Random traffic including unmapped addresses and sporadic reset.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 99) < 2);
      sel_a      = 6'($urandom_range(0, 63));
      sel_b      = ($urandom_range(0, 3) == 0) ? sel_a : 6'($urandom_range(0, 35));
      wr_en      = $urandom_range(0, 1) == 1;
      sel_c      = ($urandom_range(0, 3) == 0) ? sel_a : 6'($urandom_range(0, 40));
      data_c     = 16'($urandom);
      mem_rd_req = ($urandom_range(0, 9) == 0);
      mem_wr_req = ($urandom_range(0, 4) == 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = 16'($urandom);
      pi         = 32'($urandom);
      step();
    end

    idle_inputs();
    @(negedge clk); #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
